// File: rtl/gate_test_pkg.sv
// Shared definitions for the 2-input gate exhaustive tester.
// Holds the FSM state encoding, the number of input vectors, and the reference truth tables
// for common 2-input gates. Every truth table is indexed by v = {a, b}.
package gate_test_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StDone
  } state_e;

  localparam int unsigned NUM_VECTORS = 4;

  localparam logic [NUM_VECTORS-1:0] TT_NOR  = 4'b0001;
  localparam logic [NUM_VECTORS-1:0] TT_NAND = 4'b0111;
  localparam logic [NUM_VECTORS-1:0] TT_AND  = 4'b1000;
  localparam logic [NUM_VECTORS-1:0] TT_OR   = 4'b1110;
  localparam logic [NUM_VECTORS-1:0] TT_XOR  = 4'b0110;

endpackage

// File: rtl/gate_exhaustive_tester_if.sv
// Signal bundle between the exhaustive tester and its environment.
//   start     : begin a test run (to tester)
//   dut_out   : output of the gate under test (to tester)
//   a, b      : registered gate inputs (from tester)
//   busy      : vectors are being applied (from tester)
//   done      : one-cycle end-of-run pulse (from tester)
//   pass      : last completed run had no mismatches (from tester)
//   fail_mask : per-vector mismatch flags, bit v = {a, b} (from tester)
// The master modport is the tester side; the slave modport is the environment side.
interface gate_exhaustive_tester_if;
  import gate_test_pkg::*;

  logic                   start;
  logic                   dut_out;
  logic                   a;
  logic                   b;
  logic                   busy;
  logic                   done;
  logic                   pass;
  logic [NUM_VECTORS-1:0] fail_mask;

  modport master (
    input  start,
    input  dut_out,
    output a,
    output b,
    output busy,
    output done,
    output pass,
    output fail_mask
  );

  modport slave (
    output start,
    output dut_out,
    input  a,
    input  b,
    input  busy,
    input  done,
    input  pass,
    input  fail_mask
  );

endinterface

// File: rtl/hold_counter.sv
// Hold-window down-counter.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset, clears the count
//   load_i     : synchronous load of load_val_i (has priority over counting)
//   load_val_i : value loaded when load_i is high
//   zero_o     : count is zero
// The counter saturates at zero, so it never underflows while the owner sits idle.
module hold_counter #(
  parameter int unsigned CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/gate_exhaustive_tester.sv
// On-board exhaustive stimulus/checker for a 2-input combinational gate.
// On start, drives {a, b} = 00, 01, 10, 11, each for HOLD_CYCLES cycles, samples dut_out on the
// last edge of each hold window and compares it with EXPECT_TT[{a, b}].
// Ports:
//   clk : clock, rising edge
//   rst : asynchronous active-high reset; aborts a run without a done pulse
//   bus : master side of gate_exhaustive_tester_if (start, dut_out in; a, b, busy, done,
//         pass, fail_mask out)
module gate_exhaustive_tester
  import gate_test_pkg::*;
#(
  parameter int unsigned            HOLD_CYCLES = 100,
  parameter int unsigned            CNT_W       = 7,
  parameter logic [NUM_VECTORS-1:0] EXPECT_TT   = TT_NOR
) (
  input logic                       clk,
  input logic                       rst,
  gate_exhaustive_tester_if.master  bus
);

  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(HOLD_CYCLES - 1);

  state_e                 state_d, state_q;
  logic [1:0]             vec_d, vec_q;
  logic                   busy_d, busy_q;
  logic                   done_d, done_q;
  logic                   pass_d, pass_q;
  logic [NUM_VECTORS-1:0] fail_mask_d, fail_mask_q;
  logic [NUM_VECTORS-1:0] mask_upd;
  logic                   cnt_load;
  logic                   cnt_zero;

  hold_counter #(
    .CNT_W (CNT_W)
  ) u_hold_counter (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cnt_load),
    .load_val_i (RELOAD),
    .zero_o     (cnt_zero)
  );

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    fail_mask_d = fail_mask_q;
    cnt_load    = 1'b0;

    // Mask as it would look with the current vector's sample folded in.
    mask_upd         = fail_mask_q;
    mask_upd[vec_q]  = (bus.dut_out != EXPECT_TT[vec_q]);

    unique case (state_q)
      StIdle, StDone: begin
        if (bus.start) begin
          state_d     = StDrive;
          vec_d       = 2'd0;
          busy_d      = 1'b1;
          fail_mask_d = '0;
          pass_d      = 1'b0;
          cnt_load    = 1'b1;
        end else begin
          state_d = StIdle;
        end
      end
      StDrive: begin
        if (cnt_zero) begin
          fail_mask_d = mask_upd;
          if (vec_q == 2'd3) begin
            state_d = StDone;
            vec_d   = 2'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (mask_upd == '0);
          end else begin
            vec_d    = vec_q + 2'd1;
            cnt_load = 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      vec_q       <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      fail_mask_q <= fail_mask_d;
    end
  end

  // The vector index doubles as the gate input register: it equals {a, b} while driving and
  // is cleared on completion, so a/b come straight from flops.
  assign bus.a         = vec_q[1];
  assign bus.b         = vec_q[0];
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pass      = pass_q;
  assign bus.fail_mask = fail_mask_q;

endmodule

// File: tb/tb_gate_exhaustive_tester.sv
// Scoreboard bench for gate_exhaustive_tester: two instances (hold 4 and hold 1), a gate model
// driven by a random or directed truth table, and a monitor that checks every cycle.
module tb_gate_exhaustive_tester;
  import gate_test_pkg::*;

  typedef struct {
    bit          dut;         // 0: hold-4 instance, 1: hold-1 instance
    int unsigned start_edge;  // edge number on which start is sampled
    int unsigned hold;
    logic [3:0]  mask;
    logic        pass;
  } run_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  gate_tt = TT_NOR;
  bit          sel1 = 1'b0;
  int unsigned edge_n = 0;
  int unsigned rst_cnt = 0;
  int          checks = 0;
  int          failures = 0;
  run_t        exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;
  always @(posedge rst) rst_cnt <= rst_cnt + 1;

  gate_exhaustive_tester_if if4 ();
  gate_exhaustive_tester_if if1 ();

  gate_exhaustive_tester #(
    .HOLD_CYCLES (4),
    .CNT_W       (3),
    .EXPECT_TT   (TT_NOR)
  ) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (if4)
  );

  gate_exhaustive_tester #(
    .HOLD_CYCLES (1),
    .CNT_W       (1),
    .EXPECT_TT   (TT_NOR)
  ) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (if1)
  );

  // Gate under test: a plain truth-table lookup.
  assign if4.dut_out = gate_tt[{if4.a, if4.b}];
  assign if1.dut_out = gate_tt[{if1.a, if1.b}];

  logic       m_a, m_b, m_busy, m_done, m_pass;
  logic [3:0] m_mask;
  assign m_a    = sel1 ? if1.a         : if4.a;
  assign m_b    = sel1 ? if1.b         : if4.b;
  assign m_busy = sel1 ? if1.busy      : if4.busy;
  assign m_done = sel1 ? if1.done      : if4.done;
  assign m_pass = sel1 ? if1.pass      : if4.pass;
  assign m_mask = sel1 ? if1.fail_mask : if4.fail_mask;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h edge=%0d t=%0t", name, act, req, edge_n, $time);
    end
  endtask

  // Monitor: checks the selected instance every cycle against the front run of the queue.
  initial begin : monitor
    int unsigned seen_rst;
    logic [3:0]  last_mask [2];
    logic        last_pass [2];
    int unsigned k, n;
    run_t        r;
    seen_rst = 0;
    last_mask[0] = 4'b0; last_mask[1] = 4'b0;
    last_pass[0] = 1'b0; last_pass[1] = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (rst_cnt != seen_rst) begin
        seen_rst = rst_cnt;
        exp_q.delete();
        last_mask[0] = 4'b0; last_mask[1] = 4'b0;
        last_pass[0] = 1'b0; last_pass[1] = 1'b0;
      end
      if (exp_q.size() != 0 && edge_n >= exp_q[0].start_edge) begin
        r = exp_q[0];
        k = edge_n - r.start_edge;
        n = k / r.hold;
        if (k < 4 * r.hold) begin
          check("run_busy", {3'b0, m_busy}, 4'd1);
          check("run_ab", {2'b0, m_a, m_b}, 4'(n));
          check("run_done", {3'b0, m_done}, 4'd0);
          check("run_mask", m_mask, r.mask & 4'((1 << n) - 1));
          check("run_pass", {3'b0, m_pass}, 4'd0);
        end else begin
          check("end_done", {3'b0, m_done}, 4'd1);
          check("end_busy", {3'b0, m_busy}, 4'd0);
          check("end_ab", {2'b0, m_a, m_b}, 4'd0);
          check("end_mask", m_mask, r.mask);
          check("end_pass", {3'b0, m_pass}, {3'b0, r.pass});
          last_mask[r.dut] = r.mask;
          last_pass[r.dut] = r.pass;
          void'(exp_q.pop_front());
        end
      end else begin
        check("idle_done", {3'b0, m_done}, 4'd0);
        check("idle_busy", {3'b0, m_busy}, 4'd0);
        check("idle_ab", {2'b0, m_a, m_b}, 4'd0);
        check("idle_mask", m_mask, last_mask[sel1]);
        check("idle_pass", {3'b0, m_pass}, {3'b0, last_pass[sel1]});
      end
    end
  end

  function automatic run_t make_run(input bit use1, input int unsigned s_edge,
                                    input logic [3:0] tt);
    run_t r;
    r.dut        = use1;
    r.start_edge = s_edge;
    r.hold       = use1 ? 1 : 4;
    r.mask       = tt ^ TT_NOR;  // a vector fails wherever the gate disagrees with NOR
    r.pass       = (r.mask == 4'b0);
    return r;
  endfunction

  // Called at a negedge; returns at the next negedge with start low.
  task automatic issue_run(input bit use1, input logic [3:0] tt, output int unsigned s_edge);
    sel1    = use1;
    gate_tt = tt;
    s_edge  = edge_n + 1;
    exp_q.push_back(make_run(use1, s_edge, tt));
    if (use1) if1.start = 1'b1; else if4.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    if4.start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int cnt = 0;
    while (exp_q.size() != 0 && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=pending_runs:%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_edge(input int unsigned target);
    while (edge_n < target) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ab4"}, {2'b0, if4.a, if4.b}, 4'd0);
    check({tag, "_busy4"}, {3'b0, if4.busy}, 4'd0);
    check({tag, "_done4"}, {3'b0, if4.done}, 4'd0);
    check({tag, "_pass4"}, {3'b0, if4.pass}, 4'd0);
    check({tag, "_mask4"}, if4.fail_mask, 4'd0);
    check({tag, "_ab1"}, {2'b0, if1.a, if1.b}, 4'd0);
    check({tag, "_busy1"}, {3'b0, if1.busy}, 4'd0);
    check({tag, "_mask1"}, if1.fail_mask, 4'd0);
  endtask

  initial begin : driver
    int unsigned s;
    logic [3:0]  tt;
    if4.start = 1'b0;
    if1.start = 1'b0;

    // Asynchronous reset with no clock edge yet.
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Ideal NOR, tie-low gate, XOR gate on the hold-4 instance.
    issue_run(1'b0, TT_NOR, s);
    wait_idle(200);
    issue_run(1'b0, 4'b0000, s);
    wait_idle(200);
    issue_run(1'b0, TT_XOR, s);
    wait_idle(200);

    // Start while busy is ignored; reset mid-run aborts with no done; then a fresh full run.
    issue_run(1'b0, TT_NOR, s);
    wait_edge(s + 4);
    if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    wait_edge(s + 6);
    #1 rst = 1'b1;
    #1 check_reset_outputs("rst_midrun");
    #1 rst = 1'b0;
    wait_edge(s + 9);
    issue_run(1'b0, TT_NOR, s);
    wait_idle(200);

    // Hold-1 instance: ideal NOR, then back-to-back runs with start held through DONE.
    issue_run(1'b1, TT_NOR, s);
    wait_idle(50);
    sel1    = 1'b1;
    gate_tt = 4'b0000;
    s       = edge_n + 1;
    exp_q.push_back(make_run(1'b1, s, 4'b0000));
    exp_q.push_back(make_run(1'b1, s + 5, TT_NOR));
    if1.start = 1'b1;
    wait_edge(s + 4);
    gate_tt = TT_NOR;
    wait_edge(s + 5);
    if1.start = 1'b0;
    wait_idle(50);

    // Random gates on random instances.
    for (int i = 0; i < 10; i++) begin
      tt = 4'($urandom_range(0, 15));
      issue_run(1'($urandom_range(0, 1)), tt, s);
      wait_idle(200);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_exhaustive_tester.md
Name: gate_exhaustive_tester

Overview:
Synthesizable on-board stimulus and checker for a 2-input combinational gate under test, such as the lab's 2-input NOR. It sits directly upstream of the gate, driving its a/b inputs. It also consumes the gate's output. On start it walks all four input combinations, holds each for a programmable number of cycles, samples the gate output at the end of each hold window and compares it against an expected truth table. It reports a per-vector fail mask and an overall pass flag.

Parameters:
HOLD_CYCLES, 100, number of clk cycles each input vector is applied (>=1)
CNT_W, 7, width of the hold counter; must satisfy 2**CNT_W >= HOLD_CYCLES
EXPECT_TT, 4'b0001, expected gate output indexed by v={a,b}; default is NOR

Ports:
clk  input  1  system clock, rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a test run; sampled only in IDLE or DONE
dut_out  input  1  output of the gate under test (combinational from a/b)
a  output  1  gate input a (registered)
b  output  1  gate input b (registered)
busy  output  1  high while vectors are being applied
done  output  1  one-cycle pulse when a run completes
pass  output  1  1 when the last completed run had no mismatches; held
fail_mask  output  4  bit v set if the sample for vector v={a,b} mismatched; held

Behaviour:
- Reset (async, rst=1): FSM=IDLE; a=b=0, busy=0, done=0, pass=0, fail_mask=0, vector index v=0, counter=0. Reset mid-run aborts immediately with no done pulse.
- States: IDLE, DRIVE, DONE.
- IDLE/DONE with start=1 at edge E0: go to DRIVE. Set v=0, {a,b}=00, counter=HOLD_CYCLES-1, busy=1, fail_mask=0, pass=0.
- DRIVE: the counter decrements each edge. On the edge where counter==0 (sample edge):
  - capture dut_out as seen just before that edge;
  - set fail_mask[v] <= (dut_out != EXPECT_TT[v]);
  - if v<3: v<=v+1, {a,b}<=v+1, counter reloads HOLD_CYCLES-1;
  - if v==3: go to DONE; a=b=0, busy=0, done=1, pass <= (final fail_mask==0), including the v=3 result.
- Timing: each vector is held exactly HOLD_CYCLES cycles. Sample edges occur at E0+HOLD_CYCLES*(v+1). done is high for the single cycle after edge E0+4*HOLD_CYCLES.
- DONE lasts one cycle, then returns to IDLE unless start=1, which restarts the run directly from DONE. pass/fail_mask hold until the next start or reset.
- start while busy=1 is ignored; it causes no restart and no state change.
- HOLD_CYCLES=1: the counter is always 0, so every edge is a sample edge and the run takes 4 cycles.
- The counter never underflows. The index v wraps only by re-entering via start.
- a and b change only at sample edges or start, so they are glitch-free registered outputs.

Decomposition:
- Package gate_test_pkg holds:
  - state encoding (IDLE, DRIVE, DONE);
  - NUM_VECTORS=4;
  - truth-table constants TT_NOR=4'b0001, TT_NAND=4'b0111, TT_AND=4'b1000, TT_OR=4'b1110, TT_XOR=4'b0110, all indexed by {a,b}.
- One sub-module, hold_counter: a CNT_W down-counter with synchronous load, load value, async reset, and a zero flag. The top instantiates it once.

Test Plan:
- Reset: assert rst mid-clock with no edge -> a=b=0, busy=0, done=0, pass=0, fail_mask=4'b0000 immediately.
- Ideal NOR model, HOLD_CYCLES=4, start pulse at E0:
  - {a,b} steps 00,01,10,11, changing at E0, E4, E8, E12;
  - busy high E0..E16;
  - done high only between E16 and E17;
  - pass=1, fail_mask=4'b0000.
- dut_out tied 0, EXPECT_TT=TT_NOR, HOLD_CYCLES=4 -> fail_mask=4'b0001, pass=0, done at E16.
- dut_out driven by an XOR model, EXPECT_TT=TT_NOR -> fail_mask=4'b0111, pass=0.
- Busy and reset handling, HOLD_CYCLES=4:
  - start re-pulsed at E5 -> ignored, run unchanged;
  - rst pulsed between E6 and E7 -> all outputs 0, no done;
  - new start at E10 -> a full 16-cycle run, with done between E26 and E27.
- HOLD_CYCLES=1 with an ideal NOR -> {a,b} changes every edge; done between E4 and E5; pass=1. Start held high through DONE -> an immediate back-to-back run with fail_mask cleared at the restart edge.
